// File: rtl/moravec_pkg.sv
// moravec_pkg: shared types and constants for the corner-pipeline frame buffer
package moravec_pkg;
    typedef enum logic {ST_CLEAR, ST_RUN} ram_state_t;
    localparam int HARRIS_ZERO = 0;
    localparam int HARRIS_DROP = 1;
endpackage

// File: rtl/frame_bank.sv
// frame_bank: one frame of pixel storage, single write port, NUM_RD registered read ports
module frame_bank #(
    parameter int DEPTH   = 64,
    parameter int PIXEL_W = 8,
    parameter int ADDR_W  = 6,
    parameter int NUM_RD  = 2
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [ADDR_W-1:0]         waddr,
    input  logic [PIXEL_W-1:0]        wdata,
    input  logic [NUM_RD*ADDR_W-1:0]  raddr,
    output logic [NUM_RD*PIXEL_W-1:0] rdata
);
    logic [PIXEL_W-1:0] mem [DEPTH];
    // storage write and registered reads; out-of-range reads are masked by the top
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        for (int k = 0; k < NUM_RD; k++)
            rdata[k*PIXEL_W +: PIXEL_W] <= mem[raddr[k*ADDR_W +: ADDR_W]];
    end
endmodule

// File: rtl/frame_pingpong_ram.sv
// frame_pingpong_ram: ping-pong frame buffer with clear engine, write divider and bank swap
module frame_pingpong_ram
    import moravec_pkg::*;
#(
    parameter int N           = 8,
    parameter int PIXEL_W     = 8,
    parameter int ADDR_W      = $clog2(N*N),
    parameter int NUM_RD      = 2,
    parameter int HARRIS_MODE = HARRIS_ZERO,
    parameter int WR_DIV      = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear_req,
    output logic                      busy,
    input  logic                      wr_en,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [PIXEL_W-1:0]        wr_data,
    input  logic                      corner_bit,
    output logic                      wr_accept,
    output logic [ADDR_W:0]           wr_count,
    input  logic                      swap_req,
    output logic                      swap_done,
    output logic                      bank_sel,
    input  logic [NUM_RD*ADDR_W-1:0]  rd_addr,
    output logic [NUM_RD*PIXEL_W-1:0] rd_data
);
    localparam int PH_W = WR_DIV > 1 ? $clog2(WR_DIV) : 1;
    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(N*N);

    ram_state_t state, state_nxt;
    logic [ADDR_W-1:0]        clr_addr, waddr;
    logic [PH_W-1:0]          phase;
    logic [PIXEL_W-1:0]       wdata;
    logic [1:0]               we;
    logic [NUM_RD-1:0]        rd_zero;
    logic [NUM_RD*PIXEL_W-1:0] rd_b0, rd_b1;
    logic clr_last, wr_hit, wr_store, swap, rd_sel;

    assign busy      = state == ST_CLEAR;
    assign wr_accept = state == ST_RUN && phase == '0;
    assign clr_last  = clr_addr == ADDR_W'(N*N-1);
    assign swap      = state == ST_RUN && swap_req && !clear_req;

    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= ST_CLEAR;
        else        state <= state_nxt;

    // next state: clear runs to the last address, clear_req restarts it from RUN
    always_comb begin
        state_nxt = state;
        if (state == ST_CLEAR && clr_last) state_nxt = ST_RUN;
        if (state == ST_RUN && clear_req)  state_nxt = ST_CLEAR;
    end

    // write path: clear engine zeroes both banks, otherwise masked pixel into the write bank
    always_comb begin
        wr_hit   = wr_en && wr_accept && {1'b0, wr_addr} < DEPTH;
        wr_store = wr_hit && (corner_bit == 1'(HARRIS_MODE) || HARRIS_MODE == HARRIS_ZERO);
        waddr    = busy ? clr_addr : wr_addr;
        wdata    = (busy || corner_bit != 1'(HARRIS_MODE)) ? '0 : wr_data;
        we       = busy ? 2'b11 : {wr_store && bank_sel, wr_store && !bank_sel};
    end

    // control counters, bank select and read-side select/mask registers
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            clr_addr  <= '0;
            phase     <= '0;
            wr_count  <= '0;
            swap_done <= 1'b0;
            bank_sel  <= 1'b0;
            rd_sel    <= 1'b0;
            rd_zero   <= '1;
        end else begin
            clr_addr  <= busy && !clr_last ? clr_addr + 1'b1 : '0;
            phase     <= (busy || clear_req || phase == PH_W'(WR_DIV-1)) ? '0 : phase + 1'b1;
            wr_count  <= swap ? '0 : (wr_hit && wr_count != DEPTH) ? wr_count + 1'b1 : wr_count;
            swap_done <= swap;
            bank_sel  <= bank_sel ^ swap;
            rd_sel    <= ~bank_sel;
            for (int k = 0; k < NUM_RD; k++)
                rd_zero[k] <= busy || {1'b0, rd_addr[k*ADDR_W +: ADDR_W]} >= DEPTH;
        end

    // read data: pick the bank that was the read bank when the address was sampled
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_RD; k++)
            rd_data[k*PIXEL_W +: PIXEL_W] = rd_zero[k] ? '0 :
                (rd_sel ? rd_b1[k*PIXEL_W +: PIXEL_W] : rd_b0[k*PIXEL_W +: PIXEL_W]);
    end

    frame_bank #(.DEPTH(N*N), .PIXEL_W(PIXEL_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) u_bank0 (
        .clk(clk), .we(we[0]), .waddr(waddr), .wdata(wdata), .raddr(rd_addr), .rdata(rd_b0)
    );
    frame_bank #(.DEPTH(N*N), .PIXEL_W(PIXEL_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) u_bank1 (
        .clk(clk), .we(we[1]), .waddr(waddr), .wdata(wdata), .raddr(rd_addr), .rdata(rd_b1)
    );
endmodule

// File: tb/tb_frame_pingpong_ram.sv
// tb_frame_pingpong_ram: random stimulus on two configurations against a frame-level model
module tb_frame_pingpong_ram;
    localparam int AW = 6;

    logic clk = 1'b0, rst_n = 1'b0, clear_req = 1'b0, wr_en = 1'b0, corner_bit = 1'b0, swap_req = 1'b0;
    logic [AW-1:0]   wr_addr = '0;
    logic [7:0]      wr_data = '0;
    logic [2*AW-1:0] rd_addr = '0;
    logic            busy [2], wr_accept [2], swap_done [2], bank_sel [2];
    logic [AW:0]     wr_count [2];
    logic [15:0]     rd_data [2];

    int depth [2] = '{64, 49};
    int hm    [2] = '{0, 1};
    int dv    [2] = '{2, 1};
    logic [7:0] mem [2][2][64];
    logic [7:0] rd_exp [2][2];
    int  clr_left [2], run_cyc [2], cnt [2];
    bit  bank [2], sw_exp [2];
    int  n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    frame_pingpong_ram #(.N(8), .HARRIS_MODE(0), .WR_DIV(2)) u_a (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .busy(busy[0]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .corner_bit(corner_bit),
        .wr_accept(wr_accept[0]), .wr_count(wr_count[0]), .swap_req(swap_req),
        .swap_done(swap_done[0]), .bank_sel(bank_sel[0]), .rd_addr(rd_addr), .rd_data(rd_data[0])
    );
    frame_pingpong_ram #(.N(7), .HARRIS_MODE(1), .WR_DIV(1)) u_b (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .busy(busy[1]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .corner_bit(corner_bit),
        .wr_accept(wr_accept[1]), .wr_count(wr_count[1]), .swap_req(swap_req),
        .swap_done(swap_done[1]), .bank_sel(bank_sel[1]), .rd_addr(rd_addr), .rd_data(rd_data[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            clr_left[d] = depth[d];
            run_cyc[d]  = 0;
            cnt[d]      = 0;
            bank[d]     = 1'b0;
            sw_exp[d]   = 1'b0;
            for (int k = 0; k < 2; k++) rd_exp[d][k] = 8'h00;
            for (int b = 0; b < 2; b++)
                for (int a = 0; a < 64; a++) mem[d][b][a] = 8'h00;
        end
    endtask

    // one clock edge of a frame buffer, described as frames, counts and clear length
    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            bit is_busy = clr_left[d] > 0;
            bit acc     = !is_busy && (run_cyc[d] % dv[d]) == 0;
            int rb      = bank[d] ? 0 : 1;
            for (int k = 0; k < 2; k++) begin
                int a = int'(rd_addr[k*AW +: AW]);
                rd_exp[d][k] = (is_busy || a >= depth[d]) ? 8'h00 : mem[d][rb][a];
            end
            sw_exp[d] = 1'b0;
            if (is_busy) begin
                mem[d][0][depth[d] - clr_left[d]] = 8'h00;
                mem[d][1][depth[d] - clr_left[d]] = 8'h00;
                clr_left[d]--;
                run_cyc[d] = 0;
            end else begin
                if (wr_en && acc && int'(wr_addr) < depth[d]) begin
                    if (cnt[d] < depth[d]) cnt[d]++;
                    if (int'(corner_bit) == hm[d]) mem[d][bank[d]][wr_addr] = wr_data;
                    else if (hm[d] == 0)           mem[d][bank[d]][wr_addr] = 8'h00;
                end
                if (clear_req) clr_left[d] = depth[d];
                else if (swap_req) begin
                    bank[d]   = ~bank[d];
                    cnt[d]    = 0;
                    sw_exp[d] = 1'b1;
                end
                run_cyc[d]++;
            end
        end
    endtask

    initial begin
        int rst_hold = 3;
        bit fast = 1'b0;
        model_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (cyc % 200 == 0) fast = $urandom_range(0, 1) == 1;
            if (rst_hold == 0 && $urandom_range(0, 1499) == 0) rst_hold = $urandom_range(1, 3);
            rst_n      = rst_hold == 0;
            if (rst_hold > 0) rst_hold--;
            wr_en      = $urandom_range(0, 9) < 8;
            wr_addr    = AW'($urandom);
            wr_data    = 8'($urandom);
            corner_bit = 1'($urandom);
            rd_addr    = (2*AW)'($urandom);
            swap_req   = fast ? $urandom_range(0, 7) == 0 : $urandom_range(0, 199) == 0;
            clear_req  = $urandom_range(0, 399) == 0;
            if (cyc % 1000 == 500) begin
                clear_req = 1'b1;
                swap_req  = 1'b1;
            end
            if (!rst_n) model_reset();
            #1;
            for (int d = 0; d < 2; d++) begin
                check($sformatf("busy%0d", d), 32'(busy[d]), 32'(clr_left[d] > 0));
                check($sformatf("wr_accept%0d", d), 32'(wr_accept[d]),
                      32'(clr_left[d] == 0 && (run_cyc[d] % dv[d]) == 0));
            end
            @(posedge clk);
            if (rst_n) model_edge();
            #1;
            for (int d = 0; d < 2; d++) begin
                check($sformatf("swap_done%0d", d), 32'(swap_done[d]), 32'(sw_exp[d]));
                check($sformatf("bank_sel%0d", d), 32'(bank_sel[d]), 32'(bank[d]));
                check($sformatf("wr_count%0d", d), 32'(wr_count[d]), 32'(cnt[d]));
                for (int k = 0; k < 2; k++)
                    check($sformatf("rd_data%0d_p%0d", d, k), 32'(rd_data[d][k*8 +: 8]), 32'(rd_exp[d][k]));
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
